// File: rtl/input_port_rx.sv
// -----------------------------------------------------------------------------
// input_port_rx
//   Receive end of the leaf packet interface. Packets whose dst_port matches
//   PORT_ID are written into a 2**NUM_ADDR_BITS-entry register-array buffer at
//   the packet's addr field. The user reads them in order over a valid/ack
//   handshake. After every FREESPACE_UPDATE_SIZE words the user consumes, one
//   credit packet is queued back to the configured source leaf/port.
//
//   Optional feature macro: RX_SEQ_CHECK_EN
//     defined   : each accepted write is compared against the expected address
//                 (previous addr + 1); a mismatch sets the sticky seq_err flag.
//     undefined : no comparator and no expected-address register; seq_err = 0.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   internal_in                packet {vld, leaf, port, rsvd, addr, payload}
//   src_leaf, src_port         credit destination, loaded on update_src_en
//   update_src_en              load src_leaf/src_port on the next edge
//   dout_leaf_interface2user   head-of-buffer word
//   vld_interface2user         head word valid
//   ack_user2interface         user takes the head word when vld & ack
//   credit_out                 credit packet (0 when credit_req is low)
//   credit_req                 a credit packet is pending
//   credit_gnt                 network accepted credit_out this cycle
//   overflow                   sticky: write arrived while the buffer was full
//   seq_err                    sticky: out-of-sequence write address
// -----------------------------------------------------------------------------
module input_port_rx #(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PAYLOAD_BITS          = 64,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int PORT_ID               = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   internal_in,
  input  logic [NUM_LEAF_BITS-1:0] src_leaf,
  input  logic [NUM_PORT_BITS-1:0] src_port,
  input  logic                     update_src_en,
  output logic [PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
  output logic                     vld_interface2user,
  input  logic                     ack_user2interface,
  output logic [PACKET_BITS-1:0]   credit_out,
  output logic                     credit_req,
  input  logic                     credit_gnt,
  output logic                     overflow,
  output logic                     seq_err
);

  localparam int DEPTH     = 2 ** NUM_ADDR_BITS;
  localparam int CNT_BITS  = NUM_ADDR_BITS + 1;
  localparam int MAX_PEND  = DEPTH / FREESPACE_UPDATE_SIZE;
  localparam int RSVD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;

  // Packet field extraction
  logic                     pkt_vld;
  logic [NUM_PORT_BITS-1:0] pkt_port;
  logic [NUM_ADDR_BITS-1:0] pkt_addr;
  logic [PAYLOAD_BITS-1:0]  pkt_payload;

  assign pkt_vld     = internal_in[PACKET_BITS-1];
  assign pkt_port    = internal_in[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
  assign pkt_addr    = internal_in[PAYLOAD_BITS +: NUM_ADDR_BITS];
  assign pkt_payload = internal_in[PAYLOAD_BITS-1:0];

  // State
  logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
  logic [CNT_BITS-1:0]      count;
  logic [NUM_ADDR_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0]      cons_cnt;
  logic [CNT_BITS-1:0]      pend;
  logic [NUM_LEAF_BITS-1:0] src_leaf_r;
  logic [NUM_PORT_BITS-1:0] src_port_r;

  // Control decode
  logic hit, wr_en, drop, consume, credit_inc, grant;

  assign hit        = pkt_vld && (pkt_port == NUM_PORT_BITS'(PORT_ID));
  assign wr_en      = hit && (count != CNT_BITS'(DEPTH));
  assign drop       = hit && (count == CNT_BITS'(DEPTH));
  assign consume    = vld_interface2user && ack_user2interface;
  assign credit_inc = consume && (cons_cnt == CNT_BITS'(FREESPACE_UPDATE_SIZE - 1));
  assign grant      = credit_gnt && credit_req;

  // NOTE: the buffer has no reset on purpose; it is plain storage whose
  // contents are meaningless until written, and leaving it out of the reset
  // tree lets it map onto dense register/RAM cells.
  always_ff @(posedge clk) begin
    if (wr_en) mem[pkt_addr] <= pkt_payload;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      rd_ptr   <= '0;
      cons_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      unique case ({wr_en, consume})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;     // idle, or write and consume together
      endcase
      if (consume) begin
        rd_ptr   <= rd_ptr + 1'b1;   // natural wrap at DEPTH
        cons_cnt <= credit_inc ? '0 : cons_cnt + 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Pending-credit counter: saturates at the number of credit blocks the
  // buffer can hold; a new credit and a grant in the same cycle cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      unique case ({credit_inc, grant})
        2'b10:   if (pend != CNT_BITS'(MAX_PEND)) pend <= pend + 1'b1;
        2'b01:   pend <= pend - 1'b1;
        default: pend <= pend;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_leaf_r <= '0;
      src_port_r <= '0;
    end else if (update_src_en) begin
      src_leaf_r <= src_leaf;
      src_port_r <= src_port;
    end
  end

`ifdef RX_SEQ_CHECK_EN
  logic [NUM_ADDR_BITS-1:0] wr_exp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_exp  <= '0;
      seq_err <= 1'b0;
    end else if (wr_en) begin
      wr_exp <= pkt_addr + 1'b1;
      if (pkt_addr != wr_exp) seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

  // Outputs: combinational read of the head entry, no same-cycle bypass.
  assign vld_interface2user       = (count != '0);
  assign dout_leaf_interface2user = mem[rd_ptr];
  assign credit_req               = (pend != '0);

  // Credit packet is a pure function of registered state, so it holds steady
  // until granted and tracks any src update while pending.
  assign credit_out = credit_req
      ? {1'b1, src_leaf_r, src_port_r, {RSVD_BITS{1'b0}},
         PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)}
      : '0;

endmodule

// File: tb/tb_input_port_rx.sv
// -----------------------------------------------------------------------------
// tb_input_port_rx
//   Directed bench for input_port_rx with default parameters (DEPTH 128,
//   FREESPACE_UPDATE_SIZE 64, PORT_ID 2). Inputs are driven and outputs
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_input_port_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [96:0] internal_in;
  logic [5:0]  src_leaf;
  logic [3:0]  src_port;
  logic        update_src_en;
  logic [63:0] dout;
  logic        vld;
  logic        ack;
  logic [96:0] credit_out;
  logic        credit_req;
  logic        credit_gnt;
  logic        overflow;
  logic        seq_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  input_port_rx dut (
    .clk                      (clk),
    .reset                    (reset),
    .internal_in              (internal_in),
    .src_leaf                 (src_leaf),
    .src_port                 (src_port),
    .update_src_en            (update_src_en),
    .dout_leaf_interface2user (dout),
    .vld_interface2user       (vld),
    .ack_user2interface       (ack),
    .credit_out               (credit_out),
    .credit_req               (credit_req),
    .credit_gnt               (credit_gnt),
    .overflow                 (overflow),
    .seq_err                  (seq_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      passed++;
  endtask

  // {vld, leaf(6), port(4), rsvd(15), addr(7), payload(64)}
  function automatic logic [96:0] pkt(input logic v, input logic [3:0] port,
                                      input logic [6:0] addr, input logic [63:0] pl);
    return {v, 6'd0, port, 15'd0, addr, pl};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_src(input logic [5:0] leaf, input logic [3:0] port);
    src_leaf      = leaf;
    src_port      = port;
    update_src_en = 1'b1;
    @(negedge clk);
    update_src_en = 1'b0;
  endtask

  task automatic pulse_gnt();
    credit_gnt = 1'b1;
    @(negedge clk);
    credit_gnt = 1'b0;
  endtask

  logic seq_exp;

  initial begin
    internal_in   = '0;
    src_leaf      = '0;
    src_port      = '0;
    update_src_en = 1'b0;
    ack           = 1'b0;
    credit_gnt    = 1'b0;
`ifdef RX_SEQ_CHECK_EN
    seq_exp = 1'b1;
`else
    seq_exp = 1'b0;
`endif

    // Reset state
    do_reset();
    check("rst_vld",        vld,        0);
    check("rst_credit_req", credit_req, 0);
    check("rst_credit_out", credit_out, 0);
    check("rst_overflow",   overflow,   0);
    check("rst_seq_err",    seq_err,    0);

    // In-order delivery with ack held high
    ack = 1'b1;
    internal_in = pkt(1, 4'd2, 7'd0, 64'hAAAA);
    @(negedge clk);
    check("t1_vld_a", vld, 1);
    check("t1_dout_a", dout, 64'hAAAA);
    internal_in = pkt(1, 4'd2, 7'd1, 64'hBBBB);
    @(negedge clk);
    check("t1_dout_b", dout, 64'hBBBB);
    internal_in = pkt(1, 4'd2, 7'd2, 64'hCCCC);
    @(negedge clk);
    check("t1_dout_c", dout, 64'hCCCC);
    internal_in = '0;
    @(negedge clk);
    check("t1_vld_drop", vld, 0);

    // Filtered packets: wrong port, then valid bit clear
    ack = 1'b0;
    internal_in = pkt(1, 4'd3, 7'd3, 64'h1111);
    @(negedge clk);
    check("t2_wrong_port", vld, 0);
    internal_in = pkt(0, 4'd2, 7'd3, 64'h2222);
    @(negedge clk);
    internal_in = '0;
    check("t2_msb_clear", vld, 0);

    // Fill to DEPTH, overflow, full drain, credit generation
    do_reset();
    load_src(6'd5, 4'd3);
    for (int i = 0; i < 128; i++) begin
      internal_in = pkt(1, 4'd2, 7'(i), 64'h1000 + 64'(i));
      @(negedge clk);
    end
    check("t3_full_no_ovf", overflow, 0);
    internal_in = pkt(1, 4'd2, 7'd0, 64'hDEAD);
    @(negedge clk);
    internal_in = '0;
    check("t3_overflow", overflow, 1);
    check("t3_head_kept", dout, 64'h1000);
    ack = 1'b1;
    for (int i = 0; i < 128; i++) begin
      if (i == 63) check("t3_no_credit_63", credit_req, 0);
      if (i == 64) check("t3_credit_64",    credit_req, 1);
      check($sformatf("t3_drain_%0d", i), dout, 64'h1000 + 64'(i));
      @(negedge clk);
    end
    ack = 1'b0;
    check("t3_empty", vld, 0);
    check("t3_credit_req", credit_req, 1);
    check("t3_credit_out", credit_out, {1'b1, 6'd5, 4'd3, 22'd0, 64'd64});
    load_src(6'd7, 4'd1);
    check("t4_src_update", credit_out, {1'b1, 6'd7, 4'd1, 22'd0, 64'd64});
    pulse_gnt();
    check("t4_one_left", credit_req, 1);
    pulse_gnt();
    check("t4_all_granted", credit_req, 0);
    check("t4_credit_out_0", credit_out, 0);
    pulse_gnt();
    check("t4_idle_gnt", credit_req, 0);
    // rd_ptr wrapped back to entry 0
    internal_in = pkt(1, 4'd2, 7'd0, 64'hBEEF);
    @(negedge clk);
    internal_in = '0;
    check("t3_wrap_vld", vld, 1);
    check("t3_wrap_dout", dout, 64'hBEEF);

    // Credit increment coinciding with a grant
    do_reset();
    for (int i = 0; i < 128; i++) begin
      internal_in = pkt(1, 4'd2, 7'(i), 64'(i));
      @(negedge clk);
    end
    internal_in = '0;
    ack = 1'b1;
    repeat (64) @(negedge clk);
    check("t5_pend1", credit_req, 1);
    check("t5_credit_src0", credit_out, {1'b1, 6'd0, 4'd0, 22'd0, 64'd64});
    repeat (63) @(negedge clk);
    credit_gnt = 1'b1;
    @(negedge clk);
    credit_gnt = 1'b0;
    ack = 1'b0;
    check("t5_drained", vld, 0);
    check("t5_inc_and_gnt", credit_req, 1);
    pulse_gnt();
    check("t5_final_gnt", credit_req, 0);

    // Sequence check, then asynchronous reset mid-stream
    do_reset();
    internal_in = pkt(1, 4'd2, 7'd0, 64'hA0);
    @(negedge clk);
    check("t6_seq_ok", seq_err, 0);
    internal_in = pkt(1, 4'd2, 7'd2, 64'hA2);
    @(negedge clk);
    internal_in = pkt(1, 4'd2, 7'd3, 64'hA3);
    check("t6_seq_gap", seq_err, seq_exp);
    check("t6_vld_pre", vld, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_vld",        vld,        0);
    check("t6_rst_seq_err",    seq_err,    0);
    check("t6_rst_overflow",   overflow,   0);
    check("t6_rst_credit_req", credit_req, 0);
    check("t6_rst_credit_out", credit_out, 0);
    internal_in = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_post_rst_vld", vld, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
